// File: rtl/oflow_bbox_feeder_pkg.sv
// rtl/oflow_bbox_feeder_pkg.sv - shared widths and FSM encoding for the bbox feeder
`ifndef BBOX_VECTOR_SIZE
`define BBOX_VECTOR_SIZE 64
`endif

package oflow_bbox_feeder_pkg;
    localparam int FEED_MAX_OBJ = 32;
    localparam int FEED_ADDR_W  = 5;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
endpackage

// File: rtl/oflow_bbox_feeder_skid.sv
// rtl/oflow_bbox_feeder_skid.sv - one-entry skid register holding a read return during stall
module oflow_bbox_skid #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset_N,
    input  logic         load,
    input  logic         drain,
    input  logic [W-1:0] din,
    output logic [W-1:0] data,
    output logic         valid
);
    always_ff @(posedge clk) begin
        if (reset_N) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= din;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/oflow_bbox_feeder.sv
// rtl/oflow_bbox_feeder.sv - reads a frame's bbox list and feeds it to feature extraction
module oflow_bbox_feeder
    import oflow_bbox_feeder_pkg::*;
#(
    parameter int BBOX_W  = `BBOX_VECTOR_SIZE,
    parameter int MAX_OBJ = FEED_MAX_OBJ,
    parameter int ADDR_W  = FEED_ADDR_W,
    parameter int FE_LAT  = 1
) (
    input  logic              clk,
    input  logic              reset_N,
    input  logic              start,
    input  logic [ADDR_W:0]   num_of_bbox,
    input  logic              stall,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [BBOX_W-1:0] mem_rd_data,
    output logic [BBOX_W-1:0] bbox,
    output logic              fe_enable,
    output logic [ADDR_W-1:0] bbox_idx,
    output logic              feat_valid,
    output logic [ADDR_W-1:0] feat_idx,
    output logic              busy,
    output logic              done
);
    localparam logic [ADDR_W:0] MAX_NUM = (ADDR_W + 1)'(MAX_OBJ);

    logic [0:0]        state;
    logic [ADDR_W:0]   num_lat;
    logic [ADDR_W:0]   num_clamped;
    logic [ADDR_W:0]   issue_cnt;
    logic [ADDR_W:0]   deliver_cnt;
    logic              rd_pending;
    logic              skid_valid;
    logic              skid_load;
    logic              skid_drain;
    logic              deliver;
    logic [BBOX_W-1:0] skid_data;
    logic [BBOX_W-1:0] deliver_data;

    assign num_clamped  = (num_of_bbox > MAX_NUM) ? MAX_NUM : num_of_bbox;
    assign skid_load    = rd_pending && stall;
    assign skid_drain   = skid_valid && !stall;
    assign deliver      = !stall && (skid_valid || rd_pending);
    assign deliver_data = skid_valid ? skid_data : mem_rd_data;

    // A draining skid frees its slot this cycle, so a new read may launch alongside it.
    assign mem_rd_en = (state == ST_RUN) && !stall && (!skid_valid || skid_drain)
                       && (issue_cnt < num_lat);
    assign mem_addr  = issue_cnt[ADDR_W-1:0];
    assign busy      = (state == ST_RUN);

    oflow_bbox_skid #(
        .W(BBOX_W)
    ) u_skid (
        .clk    (clk),
        .reset_N(reset_N),
        .load   (skid_load),
        .drain  (skid_drain),
        .din    (mem_rd_data),
        .data   (skid_data),
        .valid  (skid_valid)
    );

    always_ff @(posedge clk) begin
        if (reset_N) begin
            state       <= ST_IDLE;
            num_lat     <= '0;
            issue_cnt   <= '0;
            deliver_cnt <= '0;
            rd_pending  <= 1'b0;
            bbox        <= '0;
            bbox_idx    <= '0;
            fe_enable   <= 1'b0;
            done        <= 1'b0;
        end else begin
            done       <= 1'b0;
            fe_enable  <= 1'b0;
            rd_pending <= mem_rd_en;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (num_clamped == '0) begin
                            done <= 1'b1;
                        end else begin
                            state       <= ST_RUN;
                            num_lat     <= num_clamped;
                            issue_cnt   <= '0;
                            deliver_cnt <= '0;
                        end
                    end
                end
                default: begin
                    if (mem_rd_en) begin
                        issue_cnt <= issue_cnt + 1'b1;
                    end
                    // Order is preserved, so the delivered index is simply the delivery count.
                    if (deliver) begin
                        bbox        <= deliver_data;
                        bbox_idx    <= deliver_cnt[ADDR_W-1:0];
                        fe_enable   <= 1'b1;
                        deliver_cnt <= deliver_cnt + 1'b1;
                    end
                    if (deliver_cnt == num_lat) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
            endcase
        end
    end

    logic [FE_LAT-1:0] vld_sr;
    logic [ADDR_W-1:0] idx_sr [FE_LAT];

    always_ff @(posedge clk) begin
        if (reset_N) begin
            vld_sr <= '0;
            for (int i = 0; i < FE_LAT; i++) begin
                idx_sr[i] <= '0;
            end
        end else begin
            vld_sr[0] <= fe_enable;
            idx_sr[0] <= bbox_idx;
            for (int i = 1; i < FE_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                idx_sr[i] <= idx_sr[i-1];
            end
        end
    end

    assign feat_valid = vld_sr[FE_LAT-1];
    assign feat_idx   = idx_sr[FE_LAT-1];
endmodule
